// File: rtl/stream_demux_w_id.sv
// stream_demux_w_id: steers packets from one merged stream to the output port
// selected by the head beat's id. The route stays locked for the whole packet.
// Packets whose id is out of range are discarded and counted in a saturating
// counter. All outputs come from a single registered hold stage that sustains
// one beat per cycle.
module stream_demux_w_id #(
  parameter int T_DATA_WIDTH   = 4,
  parameter int T_QOS__WIDTH   = 2,
  parameter int STREAM_COUNT   = 3,
  parameter int T_ID___WIDTH   = $clog2(STREAM_COUNT),
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [T_DATA_WIDTH-1:0]   s_data_in,
  input  logic [T_QOS__WIDTH-1:0]   s_qos_in,
  input  logic [T_ID___WIDTH-1:0]   s_id_in,
  input  logic                      s_last_in,
  input  logic                      s_valid_in,
  output logic                      s_ready_out,
  output logic [T_DATA_WIDTH-1:0]   m_data_out [STREAM_COUNT],
  output logic [T_QOS__WIDTH-1:0]   m_qos_out  [STREAM_COUNT],
  output logic [STREAM_COUNT-1:0]   m_last_out,
  output logic [STREAM_COUNT-1:0]   m_valid_out,
  input  logic [STREAM_COUNT-1:0]   m_ready_in,
  output logic [DROP_CNT_WIDTH-1:0] drop_count_out
);

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_BODY  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  // One extra bit so the limit itself is representable when STREAM_COUNT is a power of two.
  localparam logic [T_ID___WIDTH:0] ID_LIMIT = (T_ID___WIDTH + 1)'(STREAM_COUNT);

  state_t                    state_reg;
  logic [T_ID___WIDTH-1:0]   route_dest_reg;
  logic [DROP_CNT_WIDTH-1:0] drop_count_reg;

  logic [T_DATA_WIDTH-1:0]   hold_data_reg;
  logic [T_QOS__WIDTH-1:0]   hold_qos_reg;
  logic                      hold_last_reg;
  logic [T_ID___WIDTH-1:0]   hold_dest_reg;
  logic                      hold_valid_reg;

  logic                      id_valid;
  logic                      pipe_ready;
  logic                      head_drop;
  logic                      accept;
  logic                      routed_accept;
  logic                      drain;
  logic [T_ID___WIDTH-1:0]   load_dest;

  assign id_valid   = ({1'b0, s_id_in} < ID_LIMIT);
  assign pipe_ready = !hold_valid_reg || m_ready_in[hold_dest_reg];
  assign drain      = hold_valid_reg && m_ready_in[hold_dest_reg];

  // A head with a bad id is swallowed immediately, so it must not wait on a stalled output.
  assign head_drop   = (state_reg == ST_FIRST) && s_valid_in && !id_valid;
  assign s_ready_out = (state_reg == ST_DROP) || head_drop || pipe_ready;
  assign accept      = s_valid_in && s_ready_out;

  assign routed_accept = accept &&
                         (((state_reg == ST_FIRST) && id_valid) || (state_reg == ST_BODY));
  assign load_dest     = (state_reg == ST_FIRST) ? s_id_in : route_dest_reg;

  // Packet-level FSM: route lock, drop tracking and the saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_FIRST;
      route_dest_reg <= '0;
      drop_count_reg <= '0;
    end else begin
      case (state_reg)
        ST_FIRST: begin
          if (accept) begin
            if (id_valid) begin
              route_dest_reg <= s_id_in;
              if (!s_last_in) state_reg <= ST_BODY;
            end else begin
              if (drop_count_reg != '1) drop_count_reg <= drop_count_reg + 1'b1;
              if (!s_last_in) state_reg <= ST_DROP;
            end
          end
        end
        ST_BODY, ST_DROP: begin
          if (accept && s_last_in) state_reg <= ST_FIRST;
        end
        default: state_reg <= ST_FIRST;
      endcase
    end
  end

  // Output hold stage: load on a routed beat, otherwise empty once the beat is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data_reg  <= '0;
      hold_qos_reg   <= '0;
      hold_last_reg  <= 1'b0;
      hold_dest_reg  <= '0;
      hold_valid_reg <= 1'b0;
    end else if (routed_accept) begin
      hold_data_reg  <= s_data_in;
      hold_qos_reg   <= s_qos_in;
      hold_last_reg  <= s_last_in;
      hold_dest_reg  <= load_dest;
      hold_valid_reg <= 1'b1;
    end else if (drain) begin
      hold_valid_reg <= 1'b0;
    end
  end

  assign drop_count_out = drop_count_reg;

  // Payload is broadcast; only the valid of the selected port is raised.
  generate
    for (genvar gi = 0; gi < STREAM_COUNT; gi++) begin : g_port
      assign m_data_out[gi]  = hold_data_reg;
      assign m_qos_out[gi]   = hold_qos_reg;
      assign m_last_out[gi]  = hold_last_reg;
      assign m_valid_out[gi] = hold_valid_reg && (hold_dest_reg == T_ID___WIDTH'(gi));
    end
  endgenerate

endmodule

// File: doc/stream_demux_w_id.md
# stream_demux_w_id

Routing demultiplexer for the QoS-arbitrated stream bus. It takes one merged stream carrying data, qos, id and last, and steers each packet to the output port selected by its id. The route is locked for the whole packet. Packets with an out-of-range id are discarded and counted. It sits downstream of the arbiter and returns traffic to per-stream consumers through a single registered, full-throughput output stage.

## Interface
- T_DATA_WIDTH, 4, data beat width
- T_QOS__WIDTH, 2, qos field width
- STREAM_COUNT, 3, number of output streams (≥2)
- T_ID___WIDTH, $clog2(STREAM_COUNT), id field width
- DROP_CNT_WIDTH, 8, width of dropped-packet counter

Ports:
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- s_data_in  in  T_DATA_WIDTH  input beat data
- s_qos_in  in  T_QOS__WIDTH  input beat qos
- s_id_in  in  T_ID___WIDTH  destination id, sampled on first beat of packet only
- s_last_in  in  1  last beat of packet
- s_valid_in  in  1  input beat valid
- s_ready_out  out  1  input beat accepted when valid&&ready
- m_data_out  out  T_DATA_WIDTH [STREAM_COUNT]  data, broadcast to all ports
- m_qos_out  out  T_QOS__WIDTH [STREAM_COUNT]  qos, broadcast to all ports
- m_last_out  out  [STREAM_COUNT]  last, broadcast to all ports
- m_valid_out  out  [STREAM_COUNT]  one-hot (or zero) per-port valid
- m_ready_in  in  [STREAM_COUNT]  per-port ready
- drop_count_out  out  DROP_CNT_WIDTH  dropped-packet count, saturating

## Operation
- FSM states:
  - FIRST: next accepted beat is a packet head.
  - BODY: inside a routed packet.
  - DROP: inside a discarded packet.
- Head beat accepted in FIRST:
  - Valid id (s_id_in < STREAM_COUNT):
    - route_dest <= s_id_in.
    - Beat loaded into the hold register.
    - If !s_last_in, go to BODY.
  - Invalid id (s_id_in ≥ STREAM_COUNT):
    - Beat discarded; drop_count increments (saturating at all-ones).
    - If !s_last_in, go to DROP.
    - A single-beat invalid packet stays in FIRST.
- BODY:
  - Beats load into the hold register with dest = route_dest. s_id_in is ignored.
  - An accepted last beat returns the FSM to FIRST.
- DROP:
  - Beats are discarded and drop_count is unchanged.
  - An accepted last beat returns the FSM to FIRST.
- Hold register fields: data, qos, last, dest, hold_valid.
  - m_valid_out[i] = hold_valid && (dest == i).
  - data, qos and last drive all ports unchanged.
- pipe_ready = !hold_valid || m_ready_in[dest].
- s_ready_out:
  - In DROP: 1.
  - In FIRST with s_valid_in and an invalid s_id_in: 1.
  - Otherwise: pipe_ready.
- Hold register update:
  - Loaded on a routed accept.
  - Cleared when the output handshake completes and no new routed beat is accepted.
  - Simultaneous drain and load in the same cycle gives back-to-back beats at full rate.
- qos passes through per beat and is not modified.
- If STREAM_COUNT is a power of two, no id is invalid and the DROP path is unreachable.

## Timing
- Latency: a beat accepted at edge N is presented on m_*_out from edge N+1 onward.
- Throughput: one beat per cycle while the destination port is ready.
- m_valid_out stays asserted and m_data/qos/last_out stay stable until m_ready_in[dest] is high at a clock edge.
- No combinational path from s_valid_in or s_data_in to m_*_out.
- s_ready_out depends combinationally on m_ready_in[dest], state, s_valid_in and s_id_in.
- Head-of-line blocking: a stalled destination stalls the whole input, including heads for other ports.
- Reset (asynchronous assert):
  - FSM goes to FIRST; hold_valid=0; route_dest=0; drop_count_out=0.
  - m_valid_out=0 and m_data/qos/last_out=0.
  - s_ready_out=1 on the first cycle after reset deassertion.
- Reset mid-packet:
  - The packet is abandoned.
  - The next accepted beat is treated as a head.
- Saturated drop_count_out holds at 2^DROP_CNT_WIDTH−1.

## Test plan
- **Reset check:** reset, then idle. -> m_valid_out=000, drop_count_out=0, s_ready_out=1.
- **Route lock:** 3-beat packet, data 1,2,3, id=2 on the head only; id changes to 0 on later beats; all m_ready_in=1. -> m_valid_out=100 for 3 consecutive cycles starting one cycle after the head; data 1,2,3; last on beat 3 only.
- **Back-to-back packets:** id=0 single beat, then id=1 single beat in consecutive cycles. -> m_valid_out=001 then 010, no bubble.
- **Backpressure:** id=1 packet; m_ready_in[1]=0 for 4 cycles. -> s_ready_out low after the first beat; output data held stable; resumes with no beat lost or duplicated when m_ready_in[1]=1.
- **Drop path:** id=3 2-beat packet, then id=0 1-beat packet. -> no m_valid_out during the dropped packet; s_ready_out=1 throughout; drop_count_out=1; the id=0 beat is delivered next.
- **Drop counter saturation:** drop 256 single-beat id=3 packets with DROP_CNT_WIDTH=8. -> drop_count_out saturates at 255.
